// File: rtl/fifo_dict_pkg.sv
// fifo_dict shared constants and width helpers.
// Holds the default geometry and the EW/IW width functions.
package fifo_dict_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_WORDS_PER_ENTRY = 16;
  localparam int DEF_NUM_ENTRIES = 4;

  function automatic int ew_f(input int n);
    return $clog2(n);
  endfunction

  function automatic int iw_f(input int n, input int w);
    return $clog2(n * w);
  endfunction

endpackage

// File: rtl/fifo_dict_match_enc.sv
// Valid-masked word compare with lowest-index priority encode.
// In: flat storage, valid bits, key. Out: hit, flat index.
module fifo_dict_match_enc
  import fifo_dict_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH,
  parameter int N  = DEF_NUM_ENTRIES * DEF_WORDS_PER_ENTRY,
  parameter int IW = $clog2(N)
) (
  input  logic [N*DW-1:0] i_mem,
  input  logic [N-1:0]    i_valid,
  input  logic [DW-1:0]   i_key,
  output logic            o_hit,
  output logic [IW-1:0]   o_idx
);

  // Scan high to low so the lowest match is the last to win.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_valid[i] && (i_mem[i*DW +: DW] == i_key)) begin
        o_hit = 1'b1;
        o_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_dict_multi.sv
// Ring of multi-word entries with a 1-cycle associative lookup.
// Ports: write stream, lookup req/result, entry readout, status.
module fifo_dict_multi
  import fifo_dict_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WORDS_PER_ENTRY = DEF_WORDS_PER_ENTRY,
  parameter int NUM_ENTRIES     = DEF_NUM_ENTRIES
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_wr,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic i_lookup,
  input  logic [DATA_WIDTH-1:0] i_lookup_data,
  input  logic [ew_f(NUM_ENTRIES)-1:0] i_rd_entry,
  output logic [WORDS_PER_ENTRY*DATA_WIDTH-1:0] o_r_data,
  output logic o_lookup_valid,
  output logic o_hit,
  output logic [iw_f(NUM_ENTRIES, WORDS_PER_ENTRY)-1:0] o_hit_idx,
  output logic o_entry_done,
  output logic [ew_f(NUM_ENTRIES)-1:0] o_wr_entry,
  output logic [iw_f(NUM_ENTRIES, WORDS_PER_ENTRY):0] o_num_valid
);

  localparam int DW  = DATA_WIDTH;
  localparam int EW  = ew_f(NUM_ENTRIES);
  localparam int WW  = $clog2(WORDS_PER_ENTRY);
  localparam int IW  = EW + WW;
  localparam int TOT = NUM_ENTRIES * WORDS_PER_ENTRY;

  logic [DW-1:0]  mem_q [TOT];
  logic [TOT*DW-1:0] mem_flat;

  logic [WW-1:0]  widx_q, widx_d;
  logic [EW-1:0]  went_q, went_d;
  logic [TOT-1:0] valid_q, valid_d;
  logic [IW:0]    nvalid_q, nvalid_d;
  logic           lkv_q, lkv_d;
  logic           hit_q, hit_d;
  logic [IW-1:0]  hidx_q, hidx_d;
  logic           done_q, done_d;

  logic           wr_en;
  logic           last_word;
  logic [IW-1:0]  wr_addr;
  logic           enc_hit;
  logic [IW-1:0]  enc_idx;

  assign wr_en     = i_wr & ~i_clear;
  assign wr_addr   = {went_q, widx_q};
  assign last_word = (widx_q == WW'(WORDS_PER_ENTRY - 1));

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < TOT; i++) begin
      mem_flat[i*DW +: DW] = mem_q[i];
    end
  end

  always_comb begin
    o_r_data = '0;
    for (int w = 0; w < WORDS_PER_ENTRY; w++) begin
      o_r_data[w*DW +: DW] = mem_q[{i_rd_entry, WW'(w)}];
    end
  end

  fifo_dict_match_enc #(
    .DW (DW),
    .N  (TOT),
    .IW (IW)
  ) u_enc (
    .i_mem   (mem_flat),
    .i_valid (valid_q),
    .i_key   (i_lookup_data),
    .o_hit   (enc_hit),
    .o_idx   (enc_idx)
  );

  always_comb begin
    widx_d   = widx_q;
    went_d   = went_q;
    valid_d  = valid_q;
    nvalid_d = nvalid_q;
    done_d   = 1'b0;
    if (i_clear) begin
      widx_d   = '0;
      went_d   = '0;
      valid_d  = '0;
      nvalid_d = '0;
    end else if (i_wr) begin
      valid_d[wr_addr] = 1'b1;
      widx_d = widx_q + 1'b1;
      if (!valid_q[wr_addr] && nvalid_q != (IW+1)'(TOT)) begin
        nvalid_d = nvalid_q + 1'b1;
      end
      if (last_word) begin
        went_d = went_q + 1'b1;
        done_d = 1'b1;
      end
    end
  end

  // Lookup sees pre-edge state; a clear forces a miss.
  always_comb begin
    lkv_d  = i_lookup;
    hit_d  = i_lookup & ~i_clear & enc_hit;
    hidx_d = hit_d ? enc_idx : '0;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= i_w_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      widx_q   <= '0;
      went_q   <= '0;
      valid_q  <= '0;
      nvalid_q <= '0;
      lkv_q    <= 1'b0;
      hit_q    <= 1'b0;
      hidx_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      widx_q   <= widx_d;
      went_q   <= went_d;
      valid_q  <= valid_d;
      nvalid_q <= nvalid_d;
      lkv_q    <= lkv_d;
      hit_q    <= hit_d;
      hidx_q   <= hidx_d;
      done_q   <= done_d;
    end
  end

  assign o_lookup_valid = lkv_q;
  assign o_hit          = hit_q;
  assign o_hit_idx      = hidx_q;
  assign o_entry_done   = done_q;
  assign o_wr_entry     = went_q;
  assign o_num_valid    = nvalid_q;

endmodule

// File: tb/tb_fifo_dict_multi.sv
// Self-checking bench for fifo_dict_multi.
// Flat-pointer ring model, directed scenarios plus random traffic.
module tb_fifo_dict_multi;

  localparam int DW = 32;
  localparam int WPE = 16;
  localparam int NE = 4;
  localparam int TOT = WPE * NE;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  logic i_clear = 1'b0;
  logic i_wr = 1'b0;
  logic [DW-1:0] i_w_data = '0;
  logic i_lookup = 1'b0;
  logic [DW-1:0] i_lookup_data = '0;
  logic [1:0] i_rd_entry = '0;
  logic [WPE*DW-1:0] o_r_data;
  logic o_lookup_valid;
  logic o_hit;
  logic [5:0] o_hit_idx;
  logic o_entry_done;
  logic [1:0] o_wr_entry;
  logic [6:0] o_num_valid;

  fifo_dict_multi #(
    .DATA_WIDTH(DW),
    .WORDS_PER_ENTRY(WPE),
    .NUM_ENTRIES(NE)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_clear(i_clear),
    .i_wr(i_wr),
    .i_w_data(i_w_data),
    .i_lookup(i_lookup),
    .i_lookup_data(i_lookup_data),
    .i_rd_entry(i_rd_entry),
    .o_r_data(o_r_data),
    .o_lookup_valid(o_lookup_valid),
    .o_hit(o_hit),
    .o_hit_idx(o_hit_idx),
    .o_entry_done(o_entry_done),
    .o_wr_entry(o_wr_entry),
    .o_num_valid(o_num_valid)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [DW-1:0] ref_mem [TOT];
  bit ref_vld [TOT];
  bit ref_known [TOT];
  int ref_ptr = 0;
  int ref_cnt = 0;

  logic exp_lkv;
  logic exp_hit;
  int exp_idx;
  logic exp_done;

  function automatic int exp_entry();
    return ref_ptr / WPE;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TOT; i++) ref_vld[i] = 0;
    ref_ptr = 0;
    ref_cnt = 0;
    exp_lkv = 0;
    exp_hit = 0;
    exp_idx = 0;
    exp_done = 0;
  endtask

  task automatic step(input logic wr, input logic [DW-1:0] d,
                      input logic lk, input logic [DW-1:0] ld,
                      input logic clr);
    bit found;
    i_wr = wr;
    i_w_data = d;
    i_lookup = lk;
    i_lookup_data = ld;
    i_clear = clr;
    @(posedge i_clk);
    #1;
    exp_lkv = lk;
    exp_hit = 0;
    exp_idx = 0;
    found = 0;
    if (lk && !clr) begin
      for (int i = 0; i < TOT; i++) begin
        if (!found && ref_vld[i] && ref_mem[i] == ld) begin
          found = 1;
          exp_hit = 1;
          exp_idx = i;
        end
      end
    end
    exp_done = 0;
    if (clr) begin
      for (int i = 0; i < TOT; i++) ref_vld[i] = 0;
      ref_ptr = 0;
      ref_cnt = 0;
    end else if (wr) begin
      ref_mem[ref_ptr] = d;
      ref_known[ref_ptr] = 1;
      if (!ref_vld[ref_ptr]) ref_cnt++;
      ref_vld[ref_ptr] = 1;
      exp_done = (ref_ptr % WPE) == WPE - 1;
      ref_ptr = (ref_ptr + 1) % TOT;
    end
    i_wr = 0;
    i_lookup = 0;
    i_clear = 0;
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < TOT; i++) ref_known[i] = 0;
    #3;
    n_checks++;
    if ({o_lookup_valid, o_hit, o_hit_idx, o_entry_done,
         o_wr_entry, o_num_valid} !== '0)
      $display("FAIL reset_hold: got lkv=%0b hit=%0b idx=%0d done=%0b ent=%0d nv=%0d want all 0",
               o_lookup_valid, o_hit, o_hit_idx, o_entry_done, o_wr_entry, o_num_valid);
    else n_pass++;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if ({o_lookup_valid, o_hit, o_hit_idx, o_entry_done,
         o_wr_entry, o_num_valid} !== '0)
      $display("FAIL reset_after: got lkv=%0b hit=%0b idx=%0d done=%0b ent=%0d nv=%0d want all 0",
               o_lookup_valid, o_hit, o_hit_idx, o_entry_done, o_wr_entry, o_num_valid);
    else n_pass++;
  endtask

  task automatic test_fill_entry();
    int pulses = 0;
    logic [WPE*DW-1:0] exp_rd;
    for (int i = 0; i < 17; i++) begin
      step(i < 16, 32'h100 + i, 0, 0, 0);
      if (o_entry_done === 1'b1) pulses++;
      n_checks++;
      if (o_entry_done !== exp_done)
        $display("FAIL fill_done[%0d]: got %0b want %0b", i, o_entry_done, exp_done);
      else n_pass++;
    end
    n_checks++;
    if (pulses != 1)
      $display("FAIL fill_pulses: got %0d want 1", pulses);
    else n_pass++;
    n_checks++;
    if (o_wr_entry !== 2'd1)
      $display("FAIL fill_entry: got %0d want 1", o_wr_entry);
    else n_pass++;
    n_checks++;
    if (o_num_valid !== 7'd16)
      $display("FAIL fill_nvalid: got %0d want 16", o_num_valid);
    else n_pass++;
    for (int w = 0; w < WPE; w++) exp_rd[w*DW +: DW] = 32'h100 + w;
    i_rd_entry = 0;
    #1;
    n_checks++;
    if (o_r_data !== exp_rd)
      $display("FAIL fill_rdata: got %h want %h", o_r_data, exp_rd);
    else n_pass++;
  endtask

  task automatic test_lookup();
    step(0, 0, 1, 32'h105, 0);
    n_checks++;
    if ({o_lookup_valid, o_hit, o_hit_idx} !== {1'b1, 1'b1, 6'd5})
      $display("FAIL lookup_hit: got v=%0b h=%0b idx=%0d want 1 1 5",
               o_lookup_valid, o_hit, o_hit_idx);
    else n_pass++;
    step(0, 0, 1, 32'hDEAD, 0);
    n_checks++;
    if ({o_lookup_valid, o_hit, o_hit_idx} !== {1'b1, 1'b0, 6'd0})
      $display("FAIL lookup_miss: got v=%0b h=%0b idx=%0d want 1 0 0",
               o_lookup_valid, o_hit, o_hit_idx);
    else n_pass++;
    step(0, 0, 0, 32'h105, 0);
    n_checks++;
    if ({o_lookup_valid, o_hit, o_hit_idx} !== '0)
      $display("FAIL lookup_idle: got v=%0b h=%0b idx=%0d want 0 0 0",
               o_lookup_valid, o_hit, o_hit_idx);
    else n_pass++;
  endtask

  task automatic test_dup_priority();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 21; i++)
      step(1, (i == 3 || i == 20) ? 32'hAA : 32'h2000 + i, 0, 0, 0);
    step(0, 0, 1, 32'hAA, 0);
    n_checks++;
    if ({o_hit, o_hit_idx} !== {1'b1, 6'd3})
      $display("FAIL dup_prio: got h=%0b idx=%0d want 1 3", o_hit, o_hit_idx);
    else n_pass++;
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 65; i++) step(1, 32'h1000 + i, 0, 0, 0);
    n_checks++;
    if (o_num_valid !== 7'd64)
      $display("FAIL wrap_nvalid: got %0d want 64", o_num_valid);
    else n_pass++;
    n_checks++;
    if (o_wr_entry !== 2'd0)
      $display("FAIL wrap_entry: got %0d want 0", o_wr_entry);
    else n_pass++;
    i_rd_entry = 0;
    #1;
    n_checks++;
    if (o_r_data[DW-1:0] !== 32'h1040)
      $display("FAIL wrap_slot0: got %h want 00001040", o_r_data[DW-1:0]);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    step(1, 32'h77, 1, 32'h77, 0);
    n_checks++;
    if ({o_lookup_valid, o_hit} !== 2'b10)
      $display("FAIL same_cycle: got v=%0b h=%0b want 1 0", o_lookup_valid, o_hit);
    else n_pass++;
    step(0, 0, 1, 32'h77, 0);
    n_checks++;
    if ({o_hit, o_hit_idx} !== {1'b1, 6'(exp_idx)} || exp_idx != 1)
      $display("FAIL repeat_hit: got h=%0b idx=%0d want 1 1", o_hit, o_hit_idx);
    else n_pass++;
  endtask

  task automatic test_clear();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 32'h3000 + i, 0, 0, 0);
    step(1, 32'h9999, 1, 32'h3002, 1);
    n_checks++;
    if ({o_lookup_valid, o_hit, o_hit_idx} !== {1'b1, 1'b0, 6'd0})
      $display("FAIL clear_lookup: got v=%0b h=%0b idx=%0d want 1 0 0",
               o_lookup_valid, o_hit, o_hit_idx);
    else n_pass++;
    n_checks++;
    if ({o_num_valid, o_wr_entry, o_entry_done} !== '0)
      $display("FAIL clear_state: got nv=%0d ent=%0d done=%0b want 0 0 0",
               o_num_valid, o_wr_entry, o_entry_done);
    else n_pass++;
    step(1, 32'h55, 0, 0, 0);
    step(0, 0, 1, 32'h55, 0);
    i_rd_entry = 0;
    #1;
    n_checks++;
    if (o_r_data[DW-1:0] !== 32'h55 || o_num_valid !== 7'd1 ||
        {o_hit, o_hit_idx} !== {1'b1, 6'd0})
      $display("FAIL clear_next: got w0=%h nv=%0d h=%0b idx=%0d want 55 1 1 0",
               o_r_data[DW-1:0], o_num_valid, o_hit, o_hit_idx);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1, 32'h4000 + i, 0, 0, 0);
    step(0, 0, 1, 32'h4002, 0);
    n_checks++;
    if ({o_lookup_valid, o_hit, o_hit_idx} !== {1'b1, 1'b1, 6'd3})
      $display("FAIL pre_arst: got v=%0b h=%0b idx=%0d want 1 1 3",
               o_lookup_valid, o_hit, o_hit_idx);
    else n_pass++;
    #2;
    i_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({o_lookup_valid, o_hit, o_hit_idx, o_entry_done,
         o_wr_entry, o_num_valid} !== '0)
      $display("FAIL arst_now: got lkv=%0b hit=%0b idx=%0d done=%0b ent=%0d nv=%0d want all 0",
               o_lookup_valid, o_hit, o_hit_idx, o_entry_done, o_wr_entry, o_num_valid);
    else n_pass++;
    model_reset();
    #1;
    i_reset_n = 1'b1;
    step(1, 32'hBEEF, 0, 0, 0);
    step(0, 0, 1, 32'hBEEF, 0);
    i_rd_entry = 0;
    #1;
    n_checks++;
    if (o_r_data[DW-1:0] !== 32'hBEEF || o_num_valid !== 7'd1 ||
        {o_hit, o_hit_idx} !== {1'b1, 6'd0})
      $display("FAIL arst_next: got w0=%h nv=%0d h=%0b idx=%0d want beef 1 1 0",
               o_r_data[DW-1:0], o_num_valid, o_hit, o_hit_idx);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 40)),
           $urandom_range(0, 1) == 1, 32'($urandom_range(0, 40)),
           $urandom_range(0, 63) == 0);
      n_checks++;
      if ({o_lookup_valid, o_hit, o_hit_idx} !== {exp_lkv, exp_hit, 6'(exp_idx)})
        $display("FAIL rnd_lookup[%0d]: got v=%0b h=%0b idx=%0d want %0b %0b %0d",
                 n, o_lookup_valid, o_hit, o_hit_idx, exp_lkv, exp_hit, exp_idx);
      else n_pass++;
      n_checks++;
      if ({o_entry_done, o_wr_entry, o_num_valid} !==
          {exp_done, 2'(exp_entry()), 7'(ref_cnt)})
        $display("FAIL rnd_state[%0d]: got done=%0b ent=%0d nv=%0d want %0b %0d %0d",
                 n, o_entry_done, o_wr_entry, o_num_valid, exp_done, exp_entry(), ref_cnt);
      else n_pass++;
      i_rd_entry = 2'($urandom_range(0, NE - 1));
      #1;
      for (int w = 0; w < WPE; w++) begin
        if (ref_known[i_rd_entry * WPE + w]) begin
          n_checks++;
          if (o_r_data[w*DW +: DW] !== ref_mem[i_rd_entry * WPE + w])
            $display("FAIL rnd_rdata[%0d]: e=%0d w=%0d got %h want %h", n, i_rd_entry, w,
                     o_r_data[w*DW +: DW], ref_mem[i_rd_entry * WPE + w]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_entry();
    test_lookup();
    test_dup_priority();
    test_wrap();
    test_same_cycle();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
